seven_seg_scan_ctrl: RTL

//  Scan sequencer and source arbiter for the 4-digit seven-segment display device.
//  - Generates the digit-scan index and a dead-time blank strobe.
//  - Owns the 32-bit display word, arbitrating between CPU GPIO writes and a debug/test requester.
//  - Commits new words only at frame boundaries (tear-free). Feeds scanning/Disp_num into the display device.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 13 +
 rtl/seven_seg_scan_ctrl_if.sv | 20 ++
 rtl/seven_seg_scan_ctrl_scan_prescaler.sv | 30 +++
 rtl/seven_seg_scan_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, reset display word and the CPU source-select code.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    localparam logic [31:0] DEFAULT_NUM_C = 32'hAA5555AA;
    localparam logic [2:0]  SEL_CPU       = 3'd0;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Write-side bus of the scan controller: source select, CPU GPIO write
// port and the debug request/acknowledge handshake.
interface seven_seg_scan_ctrl_if;
    logic [2:0]  sel;
    logic        cpu_we;
    logic [31:0] cpu_data;
    logic        dbg_req;
    logic [31:0] dbg_data;
    logic        dbg_ack;

    modport master (
        output sel, cpu_we, cpu_data, dbg_req, dbg_data,
        input  dbg_ack
    );

    modport slave (
        input  sel, cpu_we, cpu_data, dbg_req, dbg_data,
        output dbg_ack
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_scan_prescaler.sv
// Free-running DIV_W-bit prescaler; tc flags the last count of a SHOW phase
// so the counter wraps back to zero on the same edge the FSM leaves SHOW.
module scan_prescaler #(
    parameter int DIV_W = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [DIV_W-1:0] cnt_r;

    // Prescale counter with synchronous reset and clear
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + DIV_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = en & (&cnt_r);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Digit-scan sequencer with dead-time blanking plus the display-word owner:
// arbitrates CPU/debug writes into a pending word and commits it tear-free.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int          DIV_W       = 17,
    parameter int          DEAD_CYC    = 16,
    parameter logic [31:0] DEFAULT_NUM = DEFAULT_NUM_C,
    parameter bit          TEAR_FREE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus,
    input  logic                  freeze,
    output logic [1:0]            scanning,
    output logic                  blank,
    output logic                  digit_tick,
    output logic [31:0]           disp_num
);

    localparam int              DCNT_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DCNT_W-1:0] DEAD_LAST = DCNT_W'(DEAD_CYC - 1);

    scan_state_e       state_r;
    scan_state_e       nxt_state_s;
    logic [DCNT_W-1:0] dcnt_r;
    logic [1:0]        scanning_r;
    logic              blank_r;
    logic              digit_tick_r;
    logic              dbg_ack_r;
    logic [31:0]       disp_num_r;
    logic [31:0]       pending_r;
    logic              pend_valid_r;

    logic              pre_tc_s;
    logic              show_end_s;
    logic              blank_end_s;
    logic              cpu_acc_s;
    logic              dbg_acc_s;
    logic              wr_s;
    logic [31:0]       wr_data_s;
    logic              commit_point_s;
    logic              commit_s;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (state_r == ST_SHOW),
        .clr (state_r == ST_BLANK),
        .tc  (pre_tc_s)
    );

    // Next-state decode for the SHOW/BLANK scan FSM
    always_comb begin
        nxt_state_s = state_r;
        show_end_s  = 1'b0;
        blank_end_s = 1'b0;
        case (state_r)
            ST_SHOW: begin
                if (pre_tc_s) begin
                    show_end_s  = 1'b1;
                    nxt_state_s = ST_BLANK;
                end else begin
                    nxt_state_s = ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (dcnt_r == DEAD_LAST) begin
                    blank_end_s = 1'b1;
                    nxt_state_s = ST_SHOW;
                end else begin
                    nxt_state_s = ST_BLANK;
                end
            end
            default: begin
                nxt_state_s = ST_BLANK;
            end
        endcase
    end

    // Source arbitration and commit qualification; the owner is decided by sel alone
    always_comb begin
        cpu_acc_s = (bus.sel == SEL_CPU) && bus.cpu_we;
        dbg_acc_s = (bus.sel != SEL_CPU) && bus.dbg_req;
        wr_s      = cpu_acc_s || dbg_acc_s;
        if (cpu_acc_s) begin
            wr_data_s = bus.cpu_data;
        end else begin
            wr_data_s = bus.dbg_data;
        end
        if (TEAR_FREE) begin
            commit_point_s = show_end_s && (scanning_r == 2'd3);
        end else begin
            commit_point_s = 1'b1;
        end
        commit_s = pend_valid_r && !freeze && commit_point_s;
    end

    // Scan state, dead-time counter and registered scan outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_BLANK;
            dcnt_r       <= '0;
            scanning_r   <= 2'd0;
            blank_r      <= 1'b1;
            digit_tick_r <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            blank_r      <= (nxt_state_s == ST_BLANK);
            digit_tick_r <= show_end_s;
            if (show_end_s) begin
                scanning_r <= scanning_r + 2'd1;
            end else begin
                scanning_r <= scanning_r;
            end
            if ((state_r == ST_BLANK) && !blank_end_s) begin
                dcnt_r <= dcnt_r + DCNT_W'(1);
            end else begin
                dcnt_r <= '0;
            end
        end
    end

    // Pending word, commit and debug acknowledge; a same-cycle write refills pending after commit
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r    <= DEFAULT_NUM;
            pend_valid_r <= 1'b0;
            disp_num_r   <= DEFAULT_NUM;
            dbg_ack_r    <= 1'b0;
        end else begin
            dbg_ack_r <= dbg_acc_s;
            if (commit_s) begin
                disp_num_r <= pending_r;
            end else begin
                disp_num_r <= disp_num_r;
            end
            if (wr_s) begin
                pending_r    <= wr_data_s;
                pend_valid_r <= 1'b1;
            end else if (commit_s) begin
                pending_r    <= pending_r;
                pend_valid_r <= 1'b0;
            end else begin
                pending_r    <= pending_r;
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    assign scanning    = scanning_r;
    assign blank       = blank_r;
    assign digit_tick  = digit_tick_r;
    assign disp_num    = disp_num_r;
    assign bus.dbg_ack = dbg_ack_r;

endmodule
